// File: rtl/mem_map_pkg.sv
// Shared MEM-stage memory map: peripheral addresses and timer control bit positions.
package mem_map_pkg;

  localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
  localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
  localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH  = PERIPH_BASE + 32'h10;
  localparam logic [31:0] ADDR_DIGI    = PERIPH_BASE + 32'h14;
  localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h18;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

endpackage

// File: rtl/mem_stage_periph_timer.sv
// Timer block: TH reload value, TL counter, TCON control/status and registered irq.
module periph_timer
  import mem_map_pkg::*;
#(
  parameter logic [31:0] TIMER_RST_TH = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_th,
  input  logic        i_wr_tl,
  input  logic        i_wr_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        r_irq;
  logic        w_ovf;
  logic [31:0] w_tl_nxt;
  logic [2:0]  w_tcon_nxt;

  // CPU writes win over counting; reload reads the registered (old) TH.
  always_comb begin
    w_ovf      = r_tcon[TCON_EN] && (r_tl == '1);
    w_tl_nxt   = r_tl;
    w_tcon_nxt = r_tcon;
    if (i_wr_tl)
      w_tl_nxt = i_wdata;
    else if (r_tcon[TCON_EN])
      w_tl_nxt = w_ovf ? r_th : r_tl + 32'd1;
    if (i_wr_tcon)
      w_tcon_nxt = i_wdata[2:0];
    else if (w_ovf && r_tcon[TCON_IE])
      w_tcon_nxt[TCON_ST] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= TIMER_RST_TH;
      r_tl   <= '0;
      r_tcon <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (i_wr_th)
        r_th <= i_wdata;
      r_tl   <= w_tl_nxt;
      r_tcon <= w_tcon_nxt;
      r_irq  <= w_tcon_nxt[TCON_IE] & w_tcon_nxt[TCON_ST];
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_irq;

endmodule

// File: rtl/mem_stage_periph.sv
// MEM-stage memory unit: data RAM plus memory-mapped timer, LEDs, switches, 7-seg.
// Define MEM_PERIPH_SYSTICK_EN to build the free-running SYSTICK counter.
module mem_stage_periph
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW       = 8,
  parameter logic [31:0] TIMER_RST_TH = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  logic [31:0]       r_ram [2**RAM_AW];
  logic [7:0]        r_led;
  logic [11:0]       r_digi;
  logic [31:0]       w_waddr;
  logic              w_ram_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_th;
  logic              w_wr_tl;
  logic              w_wr_tcon;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [2:0]        w_tcon;

  assign w_waddr   = Addr & ~32'h3;
  assign w_ram_sel = (Addr[31:RAM_AW+2] == '0);
  assign w_ram_idx = Addr[RAM_AW+1:2];
  assign w_wr_th   = MemWr && (w_waddr == ADDR_TH);
  assign w_wr_tl   = MemWr && (w_waddr == ADDR_TL);
  assign w_wr_tcon = MemWr && (w_waddr == ADDR_TCON);

  periph_timer #(
    .TIMER_RST_TH (TIMER_RST_TH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wr_th   (w_wr_th),
    .i_wr_tl   (w_wr_tl),
    .i_wr_tcon (w_wr_tcon),
    .i_wdata   (WriteData),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irq)
  );

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (MemWr && w_ram_sel)
      r_ram[w_ram_idx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else begin
      if (MemWr && (w_waddr == ADDR_LED))
        r_led <= WriteData[7:0];
      if (MemWr && (w_waddr == ADDR_DIGI))
        r_digi <= WriteData[11:0];
    end
  end

`ifdef MEM_PERIPH_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk) begin
    if (!reset)
      r_systick <= '0;
    else
      r_systick <= r_systick + 32'd1;
  end
`endif

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (w_ram_sel) begin
        ReadData = r_ram[w_ram_idx];
      end else begin
        case (w_waddr)
          ADDR_TH:      ReadData = w_th;
          ADDR_TL:      ReadData = w_tl;
          ADDR_TCON:    ReadData = {29'b0, w_tcon};
          ADDR_LED:     ReadData = {24'b0, r_led};
          ADDR_SWITCH:  ReadData = {24'b0, switch};
          ADDR_DIGI:    ReadData = {20'b0, r_digi};
`ifdef MEM_PERIPH_SYSTICK_EN
          ADDR_SYSTICK: ReadData = r_systick;
`endif
          default:      ReadData = '0;
        endcase
      end
    end
  end

  assign led  = r_led;
  assign digi = r_digi;

endmodule

// File: doc/mem_stage_periph.md
Name: mem_stage_periph

Overview:
- MEM-stage memory unit. Consumes the EX/MEM register outputs: MemWr, MemRd, ALUOut as the address, and DataBus_B as the write data.
- Holds the data RAM and a memory-mapped peripheral block: timer with IRQ, LEDs, switches, 7-seg digit register, optional cycle counter.
- ReadData and irq feed the MEM/WB register and the IRQ/PC control logic.

Parameters:
- RAM_AW, 8, RAM word-address width; RAM depth = 2^RAM_AW 32-bit words.
- TIMER_RST_TH, 32'h0000_0000, reset value of TH.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low.
- MemWr  in  1  write strobe from EX/MEM.
- MemRd  in  1  read strobe from EX/MEM.
- Addr  in  32  byte address (EX/MEM ALUOut).
- WriteData  in  32  store data (EX/MEM DataBus_B).
- ReadData  out  32  load data, combinational.
- switch  in  8  board switches.
- led  out  8  LED register.
- digi  out  12  7-seg register: [11:8] anode, [7:0] segments.
- irq  out  1  timer interrupt request, registered.

Behaviour:
- Reset (reset==0 at posedge): TH=TIMER_RST_TH, TL=0, TCON=0, led=0, digi=0, SYSTICK=0. RAM is not cleared.
- Decode (Addr[1:0] ignored, word access only):
  - RAM when Addr[31:RAM_AW+2]==0; index = Addr[RAM_AW+1:2].
  - 0x4000_0000 TH (RW)
  - 0x4000_0004 TL (RW)
  - 0x4000_0008 TCON[2:0] (RW): bit0 enable, bit1 irq enable, bit2 status
  - 0x4000_000C led (RW)
  - 0x4000_0010 switch (RO, zero-extended)
  - 0x4000_0014 digi (RW)
  - 0x4000_0018 SYSTICK (RO, optional)
  - Anything else is unmapped: reads 0, writes ignored.
- Reads: ReadData = decoded value when MemRd==1, else 0. Zero-latency combinational path. RW registers read back zero-extended.
- Writes: take effect at the posedge where MemWr==1. A write to a RO address is ignored.
- MemRd and MemWr both high: ReadData shows the pre-write value and the write commits at the edge.
- Timer, per cycle with TCON[0]==1:
  - TL==32'hFFFF_FFFF: TL<=TH; if TCON[1]==1, TCON[2]<=1.
  - Otherwise TL<=TL+1.
  - Wraps, no saturation.
- Timer with TCON[0]==0: TL holds and there is no overflow.
- Priority in a single cycle:
  - A CPU write to TL beats the increment/reload.
  - A CPU write to TCON beats the overflow status set. This is how software clears status: write TCON with bit2=0.
  - A CPU write to TH during overflow: the reload uses the old TH.
- irq is registered: irq <= TCON[1] & TCON[2] using next-state TCON values. It is 0 in the cycle after reset. It deasserts one cycle after the TCON write that clears the status.
- Reset asserted mid-count: all timer state returns to reset values on that edge; no pending irq survives.
- Unaligned Addr[1:0]!=0 accesses the containing word.

Optional Feature:
- Macro MEM_PERIPH_SYSTICK_EN.
- Defined: SYSTICK is a 32-bit free-running counter. It increments every non-reset cycle, wraps at 2^32, and reads at 0x4000_0018.
- Undefined: no counter is built and 0x4000_0018 is unmapped (reads 0).

Decomposition:
- Shared package mem_map_pkg holds:
  - address constants: PERIPH_BASE, ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_SWITCH, ADDR_DIGI, ADDR_SYSTICK
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_ST=2
- One sub-module, periph_timer: TH/TL/TCON registers, overflow/reload logic, registered irq. It has its own write-enable/select inputs from the top-level decoder.
- RAM stays inline in mem_stage_periph.

Test Plan:
- RAM round trip: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 -> 0xDEADBEEF; read 0x0000_0012 -> same word; with MemRd=0 -> ReadData=0.
- Timer reload and IRQ:
  - Stimulus: TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3'b011.
  - Required response: TL=0xFFFF_FFFF after 1 cycle. On the next edge TL=0xFFFF_FFFD, TCON=3'b111, and irq=1 on that same edge.
- IRQ clear:
  - Stimulus: with irq=1, write TCON=3'b011 on the same cycle as an overflow.
  - Required response: TCON=3'b011 and irq=0 one cycle later.
- Write priority: with TCON[0]=1, write TL=5 -> TL reads 5 next cycle, then 6 one cycle later.
- Peripherals: write led=0xA5, digi=0x3F0, switch=0x5A -> reads 0x0000_00A5, 0x0000_03F0, 0x0000_005A. Write to 0x4000_0010 leaves switch readback unchanged. Unmapped 0x4000_0100 reads 0.
- Reset mid-operation: timer running, irq=1, reset=0 for 1 cycle -> TL=0, TCON=0, irq=0, led=0. RAM word at 0x10 is still 0xDEADBEEF. SYSTICK, when MEM_PERIPH_SYSTICK_EN is defined, reads 0 then increments by 1 per cycle.
